// File: rtl/qpd_reference_oscillator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qpd_reference_oscillator_if                                              |
// | Tick/sync/frequency controls and sample outputs of the reference osc.    |
// | Optional: QPD_REFOSC_PHASE_OFFSET_EN adds the phase_offset_i signal.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface qpd_reference_oscillator_if #(
  parameter int NUM_BITS   = 24,
  parameter int PHASE_BITS = 32
);
  logic                         tick_i;
  logic                         sync_i;
  logic [PHASE_BITS-1:0]        freq_word_i;
`ifdef QPD_REFOSC_PHASE_OFFSET_EN
  logic [PHASE_BITS-1:0]        phase_offset_i;
`endif
  logic signed [NUM_BITS-1:0]   sin_o;
  logic signed [NUM_BITS-1:0]   cos_o;
  logic                         done_o;
  logic                         busy_o;
  logic                         overrun_o;

`ifdef QPD_REFOSC_PHASE_OFFSET_EN
  modport master (output tick_i, sync_i, freq_word_i, phase_offset_i,
                  input  sin_o, cos_o, done_o, busy_o, overrun_o);
  modport slave  (input  tick_i, sync_i, freq_word_i, phase_offset_i,
                  output sin_o, cos_o, done_o, busy_o, overrun_o);
`else
  modport master (output tick_i, sync_i, freq_word_i,
                  input  sin_o, cos_o, done_o, busy_o, overrun_o);
  modport slave  (input  tick_i, sync_i, freq_word_i,
                  output sin_o, cos_o, done_o, busy_o, overrun_o);
`endif
endinterface
`default_nettype wire

// File: rtl/qpd_reference_oscillator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qpd_reference_oscillator                                                 |
// | Phase accumulator + iterative CORDIC sine/cosine reference generator.    |
// | Optional: QPD_REFOSC_PHASE_OFFSET_EN adds a phase offset to the angle.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module qpd_reference_oscillator #(
  parameter int NUM_BITS      = 24,
  parameter int PHASE_BITS    = 32,
  parameter int CORDIC_STAGES = 20
) (
  input  wire logic                 clk_i,
  input  wire logic                 reset_i,
  qpd_reference_oscillator_if.slave bus_if
);
  localparam int XW = NUM_BITS + 2;
  localparam int ZW = PHASE_BITS + 1;
  localparam int CW = (CORDIC_STAGES > 1) ? $clog2(CORDIC_STAGES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROTATE = 2'd1;
  localparam logic [1:0] S_OUTPUT = 2'd2;

  localparam longint                AMP_L   = (longint'(1) << (NUM_BITS - 1)) - 1;
  localparam logic signed [XW-1:0]  OUT_MAX = XW'(AMP_L);
  // Start x pre-divided by the CORDIC gain so the result lands at full scale.
  localparam logic signed [XW-1:0]  X_INIT  = XW'(longint'(0.6072529350 * real'(AMP_L)));

  function automatic logic signed [ZW-1:0] atan_const(input int i);
    real t, t2, term, sum, scale;
    if (i == 0) return ZW'(longint'(1) << (PHASE_BITS - 3));
    t = 1.0;
    for (int k = 0; k < i; k++) t = t / 2.0;
    t2 = t * t; term = t; sum = 0.0;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) sum = sum + term / real'(2 * k + 1);
      else            sum = sum - term / real'(2 * k + 1);
      term = term * t2;
    end
    scale = 1.0;
    for (int k = 0; k < PHASE_BITS; k++) scale = scale * 2.0;
    return ZW'(longint'(sum * scale / 6.283185307179586));
  endfunction

  function automatic logic signed [NUM_BITS-1:0] saturate(input logic signed [XW-1:0] v);
    if (v > OUT_MAX)  return NUM_BITS'(OUT_MAX);
    if (v < -OUT_MAX) return NUM_BITS'(-OUT_MAX);
    return NUM_BITS'(v);
  endfunction

  logic signed [ZW-1:0] atan_lut [CORDIC_STAGES];
  for (genvar g = 0; g < CORDIC_STAGES; g++) begin : g_atan
    localparam logic signed [ZW-1:0] ATAN_V = atan_const(g);
    assign atan_lut[g] = ATAN_V;
  end

  logic [1:0]                  state_q, state_d;
  logic [CW-1:0]               cnt_q;
  logic [PHASE_BITS-1:0]       acc_q, acc_d;
  logic [1:0]                  quad_q;
  logic signed [XW-1:0]        x_q, y_q;
  logic signed [ZW-1:0]        z_q;
  logic signed [NUM_BITS-1:0]  sin_q, cos_q;
  logic                        done_q, busy_q, overrun_q;

  logic [PHASE_BITS-1:0]       acc_base, theta;
  logic signed [XW-1:0]        x_nx, y_nx, sin_raw, cos_raw;
  logic signed [ZW-1:0]        z_nx;

  always_comb begin
    acc_base = bus_if.sync_i ? '0 : acc_q;
`ifdef QPD_REFOSC_PHASE_OFFSET_EN
    theta    = acc_base + bus_if.phase_offset_i;
`else
    theta    = acc_base;
`endif
    // Ticks advance the phase even when refused, keeping the frequency exact.
    acc_d    = bus_if.tick_i ? acc_base + bus_if.freq_word_i : acc_base;

    if (!z_q[ZW-1]) begin
      x_nx = x_q - (y_q >>> cnt_q);
      y_nx = y_q + (x_q >>> cnt_q);
      z_nx = z_q - atan_lut[cnt_q];
    end else begin
      x_nx = x_q + (y_q >>> cnt_q);
      y_nx = y_q - (x_q >>> cnt_q);
      z_nx = z_q + atan_lut[cnt_q];
    end

    cos_raw = x_q;
    sin_raw = y_q;
    case (quad_q)
      2'd1:    begin cos_raw = -y_q; sin_raw =  x_q; end
      2'd2:    begin cos_raw = -x_q; sin_raw = -y_q; end
      2'd3:    begin cos_raw =  y_q; sin_raw = -x_q; end
      default: ;
    endcase

    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus_if.tick_i) state_d = S_ROTATE;
      S_ROTATE: if (cnt_q == CW'(CORDIC_STAGES - 1)) state_d = S_OUTPUT;
      S_OUTPUT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      quad_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      sin_q     <= '0;
      cos_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      done_q  <= 1'b0;
      busy_q  <= (state_q != S_IDLE);
      if (bus_if.tick_i && (state_q != S_IDLE)) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: if (bus_if.tick_i) begin
          x_q    <= X_INIT;
          y_q    <= '0;
          z_q    <= {3'b000, theta[PHASE_BITS-3:0]};
          quad_q <= theta[PHASE_BITS-1:PHASE_BITS-2];
          cnt_q  <= '0;
        end
        S_ROTATE: begin
          x_q   <= x_nx;
          y_q   <= y_nx;
          z_q   <= z_nx;
          cnt_q <= cnt_q + CW'(1);
        end
        S_OUTPUT: begin
          sin_q  <= saturate(sin_raw);
          cos_q  <= saturate(cos_raw);
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus_if.sin_o     = sin_q;
  assign bus_if.cos_o     = cos_q;
  assign bus_if.done_o    = done_q;
  assign bus_if.busy_o    = busy_q;
  assign bus_if.overrun_o = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_qpd_reference_oscillator.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_qpd_reference_oscillator                                              |
// | Randomized bench with a real-valued sin/cos phase model.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_qpd_reference_oscillator;
  localparam int NB  = 24;
  localparam int PB  = 32;
  localparam int ST  = 20;
  localparam int AMP = 8388607;
  // Residual angle after the last stage (~atan(2^-19) * AMP = 16 LSB) plus shift truncation.
  localparam int TOL = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qpd_reference_oscillator_if #(.NUM_BITS(NB), .PHASE_BITS(PB)) bus();
  qpd_reference_oscillator #(.NUM_BITS(NB), .PHASE_BITS(PB), .CORDIC_STAGES(ST)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus_if  (bus)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] acc_m = '0;
  logic [31:0] off_m = '0;
  logic [31:0] theta_m = '0;

  function automatic int ref_sin(input logic [31:0] th);
    return int'($sin(6.283185307179586 * real'(th) / 4294967296.0) * real'(AMP));
  endfunction
  function automatic int ref_cos(input logic [31:0] th);
    return int'($cos(6.283185307179586 * real'(th) / 4294967296.0) * real'(AMP));
  endfunction
  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_tick(input bit s, input bit accepted);
    logic [31:0] base;
    base = s ? 32'd0 : acc_m;
    if (accepted) theta_m = base + off_m;
    acc_m = base + bus.freq_word_i;
  endtask

  task automatic issue_tick(input bit s);
`ifdef QPD_REFOSC_PHASE_OFFSET_EN
    bus.phase_offset_i = off_m;
`endif
    bus.tick_i = 1'b1;
    bus.sync_i = s;
    model_tick(s, 1'b1);
    @(negedge clk);
    bus.tick_i = 1'b0;
    bus.sync_i = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.tick_i = 1'b0;
    bus.sync_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acc_m = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.tick_i = 1'b1;
    bus.sync_i = 1'b0;
    bus.freq_word_i = 32'h1234_5678;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.sin_o !== '0 || bus.cos_o !== '0) begin
      failures++; $display("FAIL reset_outputs: sin=%0d cos=%0d want 0 0", $signed(bus.sin_o), $signed(bus.cos_o));
    end
    checks++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      failures++; $display("FAIL reset_flags: done=%b busy=%b want 0 0", bus.done_o, bus.busy_o);
    end
    checks++;
    if (bus.overrun_o !== 1'b0) begin
      failures++; $display("FAIL reset_overrun: got %b want 0", bus.overrun_o);
    end
    bus.tick_i = 1'b0;
    bus.freq_word_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    acc_m = '0;
    @(negedge clk);
  endtask

  task automatic test_quadrants();
    bit ok;
    int es, ec;
    apply_reset();
    bus.freq_word_i = 32'h4000_0000;
    for (int k = 0; k < 4; k++) begin
      issue_tick(1'b0);
      wait_done(ok);
      es = ref_sin(theta_m); ec = ref_cos(theta_m);
      checks++;
      if (!ok || iabs(int'($signed(bus.sin_o)) - es) > TOL) begin
        failures++; $display("FAIL quad%0d_sin: got %0d want %0d done=%b", k, $signed(bus.sin_o), es, ok);
      end
      checks++;
      if (!ok || iabs(int'($signed(bus.cos_o)) - ec) > TOL) begin
        failures++; $display("FAIL quad%0d_cos: got %0d want %0d done=%b", k, $signed(bus.cos_o), ec, ok);
      end
    end
  endtask

  task automatic test_45deg();
    bit ok;
    apply_reset();
    bus.freq_word_i = 32'h2000_0000;
    issue_tick(1'b0);
    wait_done(ok);
    issue_tick(1'b0);
    wait_done(ok);
    checks++;
    if (!ok || iabs(int'($signed(bus.sin_o)) - 5931641) > TOL || iabs(int'($signed(bus.cos_o)) - 5931641) > TOL) begin
      failures++; $display("FAIL deg45: sin=%0d cos=%0d want 5931641 5931641 done=%b", $signed(bus.sin_o), $signed(bus.cos_o), ok);
    end
  endtask

  task automatic test_latency();
    int busy_cnt, first_busy, done_cnt, done_at, es;
    apply_reset();
    bus.freq_word_i = $urandom;
    issue_tick(1'b0);
    busy_cnt = 0; first_busy = -1; done_cnt = 0; done_at = -1;
    for (int k = 0; k < 30; k++) begin
      if (bus.busy_o) begin busy_cnt++; if (first_busy < 0) first_busy = k; end
      if (bus.done_o) begin done_cnt++; done_at = k; end
      @(negedge clk);
    end
    checks++;
    if (busy_cnt != ST + 1 || first_busy != 1) begin
      failures++; $display("FAIL latency_busy: cycles=%0d first=%0d want %0d 1", busy_cnt, first_busy, ST + 1);
    end
    checks++;
    if (done_cnt != 1 || done_at != ST + 1) begin
      failures++; $display("FAIL latency_done: pulses=%0d edge=%0d want 1 %0d", done_cnt, done_at, ST + 1);
    end
    es = ref_sin(theta_m);
    checks++;
    if (iabs(int'($signed(bus.sin_o)) - es) > TOL) begin
      failures++; $display("FAIL latency_sin: got %0d want %0d", $signed(bus.sin_o), es);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int es, ec;
    apply_reset();
    bus.freq_word_i = 32'h4000_0000;
    issue_tick(1'b0);
    repeat (4) @(negedge clk);
    bus.tick_i = 1'b1;
    model_tick(1'b0, 1'b0);
    @(negedge clk);
    bus.tick_i = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok || iabs(int'($signed(bus.sin_o))) > TOL || iabs(int'($signed(bus.cos_o)) - AMP) > TOL) begin
      failures++; $display("FAIL overrun_first: sin=%0d cos=%0d want 0 %0d done=%b", $signed(bus.sin_o), $signed(bus.cos_o), AMP, ok);
    end
    checks++;
    if (bus.overrun_o !== 1'b1) begin
      failures++; $display("FAIL overrun_set: got %b want 1", bus.overrun_o);
    end
    issue_tick(1'b0);
    wait_done(ok);
    es = ref_sin(theta_m); ec = ref_cos(theta_m);
    checks++;
    if (!ok || iabs(int'($signed(bus.sin_o)) - es) > TOL || iabs(int'($signed(bus.cos_o)) - ec) > TOL) begin
      failures++; $display("FAIL overrun_180: sin=%0d cos=%0d want %0d %0d done=%b", $signed(bus.sin_o), $signed(bus.cos_o), es, ec, ok);
    end
    checks++;
    if (bus.overrun_o !== 1'b1) begin
      failures++; $display("FAIL overrun_sticky: got %b want 1", bus.overrun_o);
    end
  endtask

  task automatic test_sync_reset();
    bit ok;
    int done_seen, es, ec;
    apply_reset();
    bus.freq_word_i = $urandom | 32'h0100_0001;
    issue_tick(1'b0); wait_done(ok);
    issue_tick(1'b0); wait_done(ok);
    issue_tick(1'b1); wait_done(ok);
    es = ref_sin(theta_m); ec = ref_cos(theta_m);
    checks++;
    if (!ok || iabs(int'($signed(bus.sin_o)) - es) > TOL || iabs(int'($signed(bus.cos_o)) - ec) > TOL) begin
      failures++; $display("FAIL sync_tick: sin=%0d cos=%0d want %0d %0d done=%b", $signed(bus.sin_o), $signed(bus.cos_o), es, ec, ok);
    end
    issue_tick(1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.sin_o !== '0 || bus.cos_o !== '0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      failures++; $display("FAIL midrot_reset: sin=%0d cos=%0d busy=%b done=%b want all 0", $signed(bus.sin_o), $signed(bus.cos_o), bus.busy_o, bus.done_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    acc_m = '0;
    done_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.done_o) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++; $display("FAIL midrot_nodone: pulses=%0d want 0", done_seen);
    end
    issue_tick(1'b0); wait_done(ok);
    es = ref_sin(theta_m); ec = ref_cos(theta_m);
    checks++;
    if (!ok || iabs(int'($signed(bus.sin_o)) - es) > TOL || iabs(int'($signed(bus.cos_o)) - ec) > TOL) begin
      failures++; $display("FAIL post_reset: sin=%0d cos=%0d want %0d %0d done=%b", $signed(bus.sin_o), $signed(bus.cos_o), es, ec, ok);
    end
  endtask

  task automatic test_random();
    bit ok, s;
    int es, ec;
    for (int k = 0; k < 10; k++) begin
      bus.freq_word_i = $urandom;
`ifdef QPD_REFOSC_PHASE_OFFSET_EN
      off_m = $urandom;
`endif
      s = ($urandom_range(0, 3) == 0);
      issue_tick(s);
      wait_done(ok);
      es = ref_sin(theta_m); ec = ref_cos(theta_m);
      checks++;
      if (!ok || iabs(int'($signed(bus.sin_o)) - es) > TOL || iabs(int'($signed(bus.cos_o)) - ec) > TOL) begin
        failures++; $display("FAIL random%0d: theta=%h sin=%0d cos=%0d want %0d %0d done=%b", k, theta_m, $signed(bus.sin_o), $signed(bus.cos_o), es, ec, ok);
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    checks++;
    if (bus.overrun_o !== 1'b0) begin
      failures++; $display("FAIL random_no_overrun: got %b want 0", bus.overrun_o);
    end
    off_m = '0;
  endtask

`ifdef QPD_REFOSC_PHASE_OFFSET_EN
  task automatic test_offset();
    bit ok;
    apply_reset();
    bus.freq_word_i = '0;
    off_m = 32'h4000_0000;
    issue_tick(1'b0);
    wait_done(ok);
    checks++;
    if (!ok || iabs(int'($signed(bus.sin_o)) - AMP) > TOL || iabs(int'($signed(bus.cos_o))) > TOL) begin
      failures++; $display("FAIL offset_90: sin=%0d cos=%0d want %0d 0 done=%b", $signed(bus.sin_o), $signed(bus.cos_o), AMP, ok);
    end
    off_m = '0;
  endtask
`endif

  initial begin
    bus.tick_i = 1'b0;
    bus.sync_i = 1'b0;
    bus.freq_word_i = '0;
`ifdef QPD_REFOSC_PHASE_OFFSET_EN
    bus.phase_offset_i = '0;
`endif
    test_reset();
    test_quadrants();
    test_45deg();
    test_latency();
    test_overrun();
    test_sync_reset();
    test_random();
`ifdef QPD_REFOSC_PHASE_OFFSET_EN
    test_offset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
